alu_share_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one alu_unit between two requesters, for example the execute stage (port 0) and a branch-compare unit (port 1).
- Accepts one operation per transaction over a valid/ready handshake.
- Drives registered operands and control to the external ALU, captures ALU_out and zero, and returns a tagged response over its own valid/ready handshake.
- At most one transaction is in flight.

---
 rtl/alu_share_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin front end that shares one external ALU between two requesters.
// One transaction in flight: accept -> one ALU settle cycle -> held response.
//
// state | meaning
// IDLE  | arbitrate; ready is given combinationally to the granted requester
// EXEC  | registered operands drive the ALU for one cycle; result captured at the edge
// RESP  | response held stable until the consumer takes it
module alu_share_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic last_grant;
  logic id_q;
  logic grant_sel;
  logic accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    state_nxt  = state;
    grant_sel  = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_sel = ~last_grant;
        end else begin
          grant_sel = req1_valid;
        end
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // ALU operands stay put after EXEC so the ALU output is stable until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 4'b0000;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= grant_sel ? req1_a  : req0_a;
      alu_b      <= grant_sel ? req1_b  : req0_b;
      alu_ctrl   <= grant_sel ? req1_op : req0_op;
      id_q       <= grant_sel;
      last_grant <= grant_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= alu_result;
        rsp_zero  <= alu_zero;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU hung off its operand outputs.
module tb_alu_share_ctrl;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;

  alu_share_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_ctrl == 4'b0110) && (alu_a == alu_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output logic id, output logic [31:0] data,
                        output logic zero, output int lat);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("acc_timeout", n < 20, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rsp_timeout", lat < 20, 1);
    id   = rsp_id;
    data = rsp_data;
    zero = rsp_zero;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic        r_id, r_zero, g;
  logic [31:0] r_data, exp_d, held_d;
  int          lat, n, i0, i1;
  logic [31:0] exp0 [4];
  logic [31:0] exp1 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp0 = '{32'd101, 32'd102, 32'd103, 32'd104};
    exp1 = '{32'd50, 32'd49, 32'd48, 32'd47};
    reset = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 0;
    tick(); tick();
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_rdy0", req0_ready, 0);
    chk("idle_rdy1", req1_ready, 0);

    // single add on port 0, including latency from accept edge to rsp_valid
    run_op(1'b0, 32'd5, 32'd3, 4'b0010, r_id, r_data, r_zero, lat);
    chk("add_id", r_id, 0);
    chk("add_data", r_data, 8);
    chk("add_zero", r_zero, 0);
    chk("add_lat", lat, 1);

    run_op(1'b1, 32'h1234, 32'h1234, 4'b0110, r_id, r_data, r_zero, lat);
    chk("cmpeq_id", r_id, 1);
    chk("cmpeq_data", r_data, 0);
    chk("cmpeq_zero", r_zero, 1);
    run_op(1'b1, 32'd7, 32'd9, 4'b0110, r_id, r_data, r_zero, lat);
    chk("cmpne_data", r_data, 32'hFFFF_FFFE);
    chk("cmpne_zero", r_zero, 0);

    // both requesters continuously valid: grants alternate starting at 0
    do_reset();
    i0 = 0; i1 = 0;
    req0_valid = 1; req0_a = 1;  req0_b = 100; req0_op = 4'b0010;
    req1_valid = 1; req1_a = 50; req1_b = 0;   req1_op = 4'b0110;
    rsp_ready = 1;
    #1;
    for (int t = 0; t < 8; t++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk("rr_timeout", n < 20, 1);
      g = req1_ready;
      chk("rr_grant", g, t % 2);
      exp_d = g ? exp1[i1 % 4] : exp0[i0 % 4];
      tick();
      if (g) begin
        i1++; req1_b = i1;
        if (i1 == 4) req1_valid = 0;
      end else begin
        i0++; req0_a = i0 + 1;
        if (i0 == 4) req0_valid = 0;
      end
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick();
        n++;
      end
      chk("rr_rsp_id", rsp_id, g);
      chk("rr_rsp_data", rsp_data, exp_d);
    end
    tick();
    rsp_ready = 0;
    req0_valid = 0; req1_valid = 0;
    tick();

    // backpressure: last grant was port 1, so port 0 wins this tie
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 4'b0010;
    req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 4'b0110;
    #1;
    chk("bp_rdy0", req0_ready, 1);
    chk("bp_rdy1", req1_ready, 0);
    tick();
    chk("bp_busy_exec", busy, 1);
    tick();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_data", rsp_data, 7);
    held_d = rsp_data;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, held_d);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_busy", busy, 1);
      chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_rel_valid", rsp_valid, 0);
    chk("bp_rel_busy", busy, 0);
    chk("bp_next_rdy1", req1_ready, 1);
    chk("bp_next_rdy0", req0_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("bp_next_busy", busy, 1);
    chk("bp_next_alu_a", alu_a, 9);
    tick();
    chk("bp2_data", rsp_data, 0);
    chk("bp2_zero", rsp_zero, 1);
    chk("bp2_id", rsp_id, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // reset while an OR is in EXEC
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 4'b0001;
    #1;
    tick();
    req0_valid = 0;
    chk("rx_ctrl_loaded", alu_ctrl, 4'b0001);
    reset = 1;
    #1;
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_ctrl", alu_ctrl, 0);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_rsp_id", rsp_id, 0);
    chk("rx_rsp_data", rsp_data, 0);
    chk("rx_busy", busy, 0);
    tick();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rx_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rx_tie_rdy0", req0_ready, 1);
    chk("rx_tie_rdy1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0101, r_id, r_data, r_zero, lat);
    chk("undef_data", r_data, 0);
    chk("undef_zero", r_zero, 0);
    run_op(1'b1, 32'hF0F0, 32'h0FF0, 4'b0000, r_id, r_data, r_zero, lat);
    chk("and_data", r_data, 32'h00F0);
    chk("and_id", r_id, 1);
    run_op(1'b0, 32'hF0F0, 32'h0FF0, 4'b0001, r_id, r_data, r_zero, lat);
    chk("or_data", r_data, 32'hFFF0);
    chk("or_id", r_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
